// File: rtl/cordic_prep_stage.sv
// ---------------------------------------------------------------------------
// cordic_prep_stage
//
// Prepares an IEEE-754 single-precision operand for a fixed-point CORDIC core.
// One transaction at a time: the operand is captured on accept, and after a
// programmable number of enabled cycles the block presents
//   - half  : x/2 in single precision (flush-to-zero on the smallest normals)
//   - x_fix : |x|*2^FRAC_W truncated, signed, optionally minus OFFSET_FIX,
//             saturated to OUT_W bits
//   - sat   : conversion clamped / saturated, or x was NaN/Inf
// The results are held until the downstream side consumes them.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_clk_en     clock enable; low freezes FSM, counter and output registers
//   i_in_valid   i_x / i_sub_en carry a transaction
//   o_in_ready   block idle and able to accept
//   i_x          single-precision operand
//   i_sub_en     subtract OFFSET_FIX from the converted value
//   o_out_valid  results valid and held
//   i_out_ready  downstream consumes the results
//   o_half       x/2, single precision
//   o_x_fix      signed fixed-point operand, OUT_W bits
//   o_sat        clamp/saturation/NaN/Inf flag
// ---------------------------------------------------------------------------
module cordic_prep_stage #(
    parameter int                       FRAC_W     = 14,
    parameter int                       OUT_W      = 22,
    parameter logic signed [OUT_W+1:0]  OFFSET_FIX = (OUT_W+2)'(2097152),
    parameter int                       LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clk_en,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [31:0]             i_x,
    input  logic                    i_sub_en,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [31:0]             o_half,
    output logic signed [OUT_W-1:0] o_x_fix,
    output logic                    o_sat
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    // Wide enough for the 24-bit significand shifted left by up to OUT_W+1.
    localparam int MAG_W = 24 + OUT_W + 2;
    localparam logic [MAG_W-1:0] MAG_LIM =
        {{(MAG_W-OUT_W-1){1'b0}}, {(OUT_W+1){1'b1}}};

    localparam logic signed [OUT_W+2:0] X_MAX = {{4{1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W+2:0] X_MIN = {{4{1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [31:0]            r_x;
    logic                   r_sub_en;
    logic                   w_accept;
    logic                   w_load_out;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_out   = 1'b0;
        o_in_ready   = (r_state == S_IDLE);
        o_out_valid  = (r_state == S_HOLD);
        if (i_clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        w_load_out   = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Consume only; a simultaneous in_valid waits for IDLE.
                    if (i_out_ready) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Latency counter and operand capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_sub_en <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= CNT_LOAD;
            r_x      <= i_x;
            r_sub_en <= i_sub_en;
        end else if (i_clk_en && (r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath on the captured operand
    // -----------------------------------------------------------------------
    logic [7:0]              w_exp;
    logic [23:0]             w_sig;
    logic                    w_sign;
    int                      w_sh;
    logic [MAG_W-1:0]        w_wide;
    logic [OUT_W:0]          w_mag;
    logic                    w_clamp;
    logic                    w_nan;
    logic signed [OUT_W+1:0] w_conv;
    logic signed [OUT_W+2:0] w_diff;
    logic signed [OUT_W-1:0] w_x_fix;
    logic                    w_osat;
    logic [31:0]             w_half;

    assign w_exp  = r_x[30:23];
    assign w_sig  = {1'b1, r_x[22:0]};
    assign w_sign = r_x[31];

    // value = sig * 2^(e-150); scaled by 2^FRAC_W this is a shift by w_sh.
    assign w_sh = int'(w_exp) - 150 + FRAC_W;

    always_comb begin
        w_wide  = '0;
        w_mag   = '0;
        w_clamp = 1'b0;
        w_nan   = 1'b0;
        if (w_exp == 8'hFF) begin
            if (r_x[22:0] != '0) begin
                w_nan = 1'b1;
            end else begin
                w_clamp = 1'b1;
            end
        end else if (w_exp == 8'h00) begin
            w_mag = '0;                         // denormals and zero
        end else if (w_sh > OUT_W + 1) begin
            w_clamp = 1'b1;                     // sig >= 1, so surely over limit
        end else begin
            if (w_sh >= 0) begin
                w_wide = MAG_W'(w_sig) << w_sh;
            end else if (w_sh > -24) begin
                w_wide = MAG_W'(w_sig) >> (-w_sh);
            end else begin
                w_wide = '0;
            end
            if (w_wide > MAG_LIM) begin
                w_clamp = 1'b1;
            end else begin
                w_mag = w_wide[OUT_W:0];
            end
        end
        if (w_clamp) begin
            w_mag = {(OUT_W+1){1'b1}};
        end
    end

    always_comb begin
        w_conv  = w_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
        w_diff  = $signed({w_conv[OUT_W+1], w_conv})
                - (r_sub_en ? $signed({OFFSET_FIX[OUT_W+1], OFFSET_FIX})
                            : $signed({(OUT_W+3){1'b0}}));
        w_osat  = 1'b0;
        w_x_fix = w_diff[OUT_W-1:0];
        if (w_diff > X_MAX) begin
            w_x_fix = {1'b0, {(OUT_W-1){1'b1}}};
            w_osat  = 1'b1;
        end else if (w_diff < X_MIN) begin
            w_x_fix = {1'b1, {(OUT_W-1){1'b0}}};
            w_osat  = 1'b1;
        end
    end

    always_comb begin
        if (w_exp <= 8'd1) begin
            w_half = {w_sign, 31'b0};           // e=1 would go denormal: flush
        end else if (w_exp == 8'hFF) begin
            w_half = r_x;
        end else begin
            w_half = {w_sign, w_exp - 8'd1, r_x[22:0]};
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_half  <= '0;
            o_x_fix <= '0;
            o_sat   <= 1'b0;
        end else if (w_load_out) begin
            o_half  <= w_half;
            o_x_fix <= w_x_fix;
            o_sat   <= w_nan | w_clamp | w_osat;
        end
    end

endmodule

// File: tb/tb_cordic_prep_stage.sv
module tb_cordic_prep_stage;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_clk_en;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_x;
    logic        i_sub_en;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_half;
    logic [21:0] o_x_fix;
    logic        o_sat;

    int n_vec = 0;
    int n_err = 0;

    cordic_prep_stage #(
        .FRAC_W    (14),
        .OUT_W     (22),
        .OFFSET_FIX(24'sd2097152),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_en   (i_clk_en),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_x        (i_x),
        .i_sub_en   (i_sub_en),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_half     (o_half),
        .o_x_fix    (o_x_fix),
        .o_sat      (o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic        sub;
        logic [31:0] h;
        logic [21:0] f;
        logic        s;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued |x|*2^14, truncated, clamped, offset, saturated.
    task automatic model(input logic [31:0] x, input logic sub,
                         output logic [31:0] h, output logic [21:0] f,
                         output logic s);
        logic [7:0] e;
        real        mag;
        longint     conv;
        longint     diff;
        e    = x[30:23];
        s    = 1'b0;
        conv = 0;
        if (e == 8'hFF) begin
            s    = 1'b1;
            conv = (x[22:0] != 0) ? 0 : 8388607;
        end else if (e != 0) begin
            // rebuild the single as a double of the same magnitude
            mag = $bitstoreal({1'b0, 11'(e) + 11'd896, x[22:0], 29'b0}) * 16384.0;
            if (mag >= 8388608.0) begin
                conv = 8388607;
                s    = 1'b1;
            end else begin
                conv = longint'($rtoi(mag));
            end
        end
        if (x[31]) conv = -conv;
        diff = conv - (sub ? 2097152 : 0);
        if (diff > 2097151) begin
            diff = 2097151;
            s    = 1'b1;
        end else if (diff < -2097152) begin
            diff = -2097152;
            s    = 1'b1;
        end
        f = diff[21:0];
        if (e <= 1)          h = {x[31], 31'b0};
        else if (e == 8'hFF) h = x;
        else                 h = {x[31], e - 8'd1, x[22:0]};
    endtask

    // Accept one operand, measure latency, check results, consume.
    task automatic do_txn(input logic [31:0] x, input logic sub,
                          input logic [31:0] h, input logic [21:0] f,
                          input logic s, input int hold_cycles,
                          input string tag);
        int n;
        n = 0;
        while (!o_in_ready && n < 200) begin tick(); n++; end
        chk({tag, " in_ready"}, longint'(o_in_ready), 1);
        i_in_valid = 1'b1;
        i_x        = x;
        i_sub_en   = sub;
        tick();
        i_in_valid = 1'b0;
        i_x        = $urandom;
        i_sub_en   = ~sub;
        n = 0;
        while (!o_out_valid && n < 2000) begin tick(); n++; end
        chk({tag, " latency"}, longint'(n), longint'(LAT));
        for (int k = 0; k < hold_cycles; k++) tick();
        chk({tag, " half"}, longint'(o_half), longint'(h));
        chk({tag, " x_fix"}, longint'(o_x_fix), longint'(f));
        chk({tag, " sat"}, longint'(o_sat), longint'(s));
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk({tag, " idle"}, longint'({o_out_valid, o_in_ready}), 1);
        $display("txn %s x=%08h sub=%0d -> half=%08h x_fix=%06h sat=%0d",
                 tag, x, sub, o_half, o_x_fix, o_sat);
    endtask

    initial begin
        logic [31:0] h, h2;
        logic [21:0] f, f2;
        logic        s, s2;
        logic [31:0] x;
        logic [31:0] hold_h;
        logic [21:0] hold_f;
        int          n;
        int          seen;

        tbl[0]  = '{32'h43000000, 1'b1, 32'h42800000, 22'h000000, 1'b0};
        tbl[1]  = '{32'h3F800000, 1'b1, 32'h3F000000, 22'h204000, 1'b0};
        tbl[2]  = '{32'h44800000, 1'b0, 32'h44000000, 22'h1FFFFF, 1'b1};
        tbl[3]  = '{32'h7FC00000, 1'b0, 32'h7FC00000, 22'h000000, 1'b1};
        tbl[4]  = '{32'hBF800000, 1'b0, 32'hBF000000, 22'h3FC000, 1'b0};
        tbl[5]  = '{32'h00000001, 1'b0, 32'h00000000, 22'h000000, 1'b0};
        tbl[6]  = '{32'hFF800000, 1'b1, 32'hFF800000, 22'h200000, 1'b1};
        tbl[7]  = '{32'h80800000, 1'b0, 32'h80000000, 22'h000000, 1'b0};
        tbl[8]  = '{32'h42C90000, 1'b0, 32'h42490000, 22'h192000, 1'b0};
        tbl[9]  = '{32'h38800000, 1'b0, 32'h38000000, 22'h000001, 1'b0};
        tbl[10] = '{32'hC3000000, 1'b0, 32'hC2800000, 22'h200000, 1'b0};

        rst_n       = 1'b0;
        i_clk_en    = 1'b1;
        i_in_valid  = 1'b0;
        i_x         = '0;
        i_sub_en    = 1'b0;
        i_out_ready = 1'b0;
        #1;
        chk("reset state",
            longint'({o_in_ready, o_out_valid, o_sat, o_x_fix, o_half}),
            longint'({1'b1, 1'b0, 1'b0, 22'h0, 32'h0}));
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // directed vectors
        for (int i = 0; i < 11; i++) begin
            do_txn(tbl[i].x, tbl[i].sub, tbl[i].h, tbl[i].f, tbl[i].s, 0,
                   $sformatf("vec%0d", i));
        end

        // out_ready low for 10 cycles in HOLD with in_valid asserted
        i_in_valid = 1'b1; i_x = 32'h3F800000; i_sub_en = 1'b1;
        tick();
        i_x = 32'h40000000; i_sub_en = 1'b0;   // 2.0, stays offered
        n = 0;
        while (!o_out_valid && n < 100) begin tick(); n++; end
        chk("hold latency", longint'(n), longint'(LAT));
        hold_h = o_half; hold_f = o_x_fix;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_half != 32'h3F000000 || o_x_fix != 22'h204000 ||
                o_in_ready || !o_out_valid) seen++;
        end
        chk("hold stable", longint'(seen), 0);
        chk("hold value", longint'({hold_h, hold_f}),
            longint'({32'h3F000000, 22'h204000}));
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("consume only", longint'({o_out_valid, o_in_ready}), 1);
        tick();
        chk("accept after consume", longint'(o_in_ready), 0);
        i_in_valid = 1'b0;
        n = 0;
        while (!o_out_valid && n < 100) begin tick(); n++; end
        chk("second latency", longint'(n), longint'(LAT));
        chk("second x_fix", longint'(o_x_fix), longint'(22'h008000));
        chk("second half", longint'(o_half), longint'(32'h3F800000));
        // clk_en low in HOLD blocks consume
        i_clk_en = 1'b0; i_out_ready = 1'b1;
        tick(); tick();
        chk("hold frozen", longint'(o_out_valid), 1);
        i_clk_en = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("consumed", longint'(o_in_ready), 1);
        $display("txn hold-sequence done");

        // clk_en low in IDLE: no accept
        i_clk_en = 1'b0; i_in_valid = 1'b1; i_x = 32'h43000000; i_sub_en = 1'b1;
        tick(); tick();
        chk("idle frozen", longint'(o_in_ready), 1);
        // clk_en low 3 cycles mid-BUSY
        i_clk_en = 1'b1;
        tick();
        i_in_valid = 1'b0;
        tick(); tick();
        i_clk_en = 1'b0;
        tick(); tick(); tick();
        i_clk_en = 1'b1;
        n = 5;
        while (!o_out_valid && n < 100) begin tick(); n++; end
        chk("stall latency", longint'(n), longint'(LAT + 3));
        chk("stall x_fix", longint'(o_x_fix), 0);
        chk("stall half", longint'(o_half), longint'(32'h42800000));
        i_out_ready = 1'b1; tick(); i_out_ready = 1'b0;
        $display("txn clk_en stall done");

        // reset mid-BUSY, between edges
        do_txn(32'h3F800000, 1'b1, 32'h3F000000, 22'h204000, 1'b0, 0, "pre-rst");
        i_in_valid = 1'b1; i_x = 32'h44800000; i_sub_en = 1'b0;
        tick();
        i_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst outputs",
            longint'({o_in_ready, o_out_valid, o_sat, o_x_fix, o_half}),
            longint'({1'b1, 1'b0, 1'b0, 22'h0, 32'h0}));
        #2 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (o_out_valid) seen++;
        end
        chk("no valid after rst", longint'(seen), 0);
        do_txn(32'h42C90000, 1'b0, 32'h42490000, 22'h192000, 1'b0, 0, "post-rst");

        // randomized against the model
        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            if (i % 2 == 0) x[30:23] = 8'($urandom_range(110, 155));
            s = 1'($urandom);
            model(x, s, h2, f2, s2);
            do_txn(x, s, h2, f2, s2, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
